// File: rtl/gate_vector_checker_pkg.sv
// Shared types and constants for the gate vector checker: FSM state encoding,
// default vector count and the common 2-input truth tables.
package gate_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int NUM_IN_DEF = 2;
  localparam int NUM_VEC    = 1 << NUM_IN_DEF;

  // Bit index of each table is the input vector value {A,B}
  localparam logic [3:0] TT_NAND2 = 4'b0111;
  localparam logic [3:0] TT_NOR2  = 4'b0001;
  localparam logic [3:0] TT_XOR2  = 4'b0110;

endpackage

// File: rtl/gate_vector_checker_if.sv
// Stimulus/response bundle between the checker (slave) and whoever owns the
// gate under test and the start/result handshake (master).
interface gate_vector_checker_if #(
  parameter int NUM_IN = 2,
  parameter int CNT_W  = 4
);
  logic              start;
  logic              y_i;
  logic [NUM_IN-1:0] vec_o;
  logic              busy;
  logic              done;
  logic              pass;
  logic [CNT_W-1:0]  err_cnt;
  logic [NUM_IN-1:0] fail_vec;

  modport master (
    output start, y_i,
    input  vec_o, busy, done, pass, err_cnt, fail_vec
  );

  modport slave (
    input  start, y_i,
    output vec_o, busy, done, pass, err_cnt, fail_vec
  );
endinterface

// File: rtl/gate_vector_checker_settle_timer.sv
// Settle down-counter: loaded with SETTLE_CYC when a vector is driven,
// pulses expire on the last DRIVE cycle so the next edge moves to SAMPLE.
module settle_timer #(
  parameter int SETTLE_CYC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                    cnt_d = 8'(SETTLE_CYC);
    else if (en && cnt_q != '0)  cnt_d = cnt_q - 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expire = en && (cnt_q == 8'd1);
endmodule

// File: rtl/gate_vector_checker.sv
// Clocked exerciser that sweeps every input vector of a combinational gate and
// compares y_i with TRUTH_TABLE. GATE_CHK_STOP_ON_FAIL_EN: halt on first mismatch.
module gate_vector_checker
  import gate_chk_pkg::*;
#(
  parameter int                     NUM_IN      = 2,
  parameter logic [(1<<NUM_IN)-1:0] TRUTH_TABLE = TT_NAND2,
  parameter int                     SETTLE_CYC  = 2,
  parameter int                     CNT_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gate_vector_checker_if.slave bus
);
  localparam logic [NUM_IN-1:0] LAST_VEC = {NUM_IN{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  state_e            state_q, state_d;
  logic [NUM_IN-1:0] vec_q, vec_d, fail_vec_q, fail_vec_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic              fail_seen_q, fail_seen_d;
  logic              tmr_load, tmr_expire, mismatch, start_ok;

  assign mismatch = (bus.y_i != TRUTH_TABLE[vec_q]);
  assign start_ok = bus.start && (state_q == IDLE || state_q == DONE);

  settle_timer #(.SETTLE_CYC(SETTLE_CYC)) u_settle (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .en     (state_q == DRIVE),
    .expire (tmr_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (bus.start) state_d = DRIVE;
      DRIVE:      if (tmr_expire) state_d = SAMPLE;
      SAMPLE: begin
`ifdef GATE_CHK_STOP_ON_FAIL_EN
        if (mismatch || vec_q == LAST_VEC) state_d = DONE;
        else                               state_d = DRIVE;
`else
        if (vec_q == LAST_VEC) state_d = DONE;
        else                   state_d = DRIVE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Sweep datapath; y_i only matters on the SAMPLE edge
  always_comb begin
    vec_d       = vec_q;
    err_d       = err_q;
    fail_vec_d  = fail_vec_q;
    fail_seen_d = fail_seen_q;
    tmr_load    = 1'b0;
    if (start_ok) begin
      vec_d       = '0;
      err_d       = '0;
      fail_vec_d  = '0;
      fail_seen_d = 1'b0;
      tmr_load    = 1'b1;
    end else if (state_q == SAMPLE) begin
      if (mismatch) begin
        if (err_q != CNT_MAX) err_d = err_q + 1'b1;
        if (!fail_seen_q) begin
          fail_vec_d  = vec_q;
          fail_seen_d = 1'b1;
        end
      end
      if (state_d == DRIVE) begin
        vec_d    = vec_q + 1'b1;
        tmr_load = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q       <= '0;
      err_q       <= '0;
      fail_vec_q  <= '0;
      fail_seen_q <= 1'b0;
    end else begin
      vec_q       <= vec_d;
      err_q       <= err_d;
      fail_vec_q  <= fail_vec_d;
      fail_seen_q <= fail_seen_d;
    end
  end

  always_comb begin
    bus.busy     = (state_q == DRIVE) || (state_q == SAMPLE);
    bus.done     = (state_q == DONE);
    bus.pass     = (state_q == DONE) && (err_q == '0);
    bus.vec_o    = vec_q;
    bus.err_cnt  = err_q;
    bus.fail_vec = fail_vec_q;
  end
endmodule

// File: tb/tb_gate_vector_checker.sv
// Randomized bench for gate_vector_checker: two configurations swept side by side
// against a per-vector model of the expected count, first fail and finish edge.
module tb_gate_vector_checker;
  import gate_chk_pkg::*;

  localparam int S0 = 2, C0 = 4;
  localparam int S1 = 4, C1 = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gate_vector_checker_if #(.NUM_IN(2), .CNT_W(C0)) if0();
  gate_vector_checker_if #(.NUM_IN(2), .CNT_W(C1)) if1();

  gate_vector_checker #(.NUM_IN(2), .TRUTH_TABLE(TT_NAND2), .SETTLE_CYC(S0), .CNT_W(C0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  gate_vector_checker #(.NUM_IN(2), .TRUTH_TABLE(TT_XOR2), .SETTLE_CYC(S1), .CNT_W(C1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  // Gate under test: behaviour table plus an optional glitch overlay
  logic [3:0] gate0, gate1;
  logic       gl0, gl1;
  assign if0.y_i = gate0[if0.vec_o] ^ gl0;
  assign if1.y_i = gate1[if1.vec_o] ^ gl1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected results of one sweep from the truth table and the gate's real behaviour
  function automatic void model(input logic [3:0] tt, input logic [3:0] gt, input int s,
                                input int cmax, output int err, output int fvec,
                                output int dedge, output int lastv, output int ok);
    int n = 0;
    int f = -1;
    for (int v = 0; v < 4; v++)
      if (tt[v] != gt[v]) begin
        n++;
        if (f < 0) f = v;
      end
`ifdef GATE_CHK_STOP_ON_FAIL_EN
    if (f >= 0) begin
      err = 1; fvec = f; dedge = (f + 1) * (s + 1); lastv = f;
    end else begin
      err = 0; fvec = 0; dedge = 4 * (s + 1); lastv = 3;
    end
`else
    err   = (n > cmax) ? cmax : n;
    fvec  = (f < 0) ? 0 : f;
    dedge = 4 * (s + 1);
    lastv = 3;
`endif
    ok = (f < 0) ? 1 : 0;
  endfunction

  task automatic run_sweep(input string nm, input logic [3:0] g0, input logic [3:0] g1,
                           input bit glitch, input bit repulse);
    int e0, f0, d0, l0, p0, e1, f1, d1, l1, p1;
    int de0, de1;
    bit rp;
    model(TT_NAND2, g0, S0, (1 << C0) - 1, e0, f0, d0, l0, p0);
    model(TT_XOR2,  g1, S1, (1 << C1) - 1, e1, f1, d1, l1, p1);
    rp = repulse && (d0 > 4) && (d1 > 4);
    gate0 = g0; gate1 = g1; gl0 = 1'b0; gl1 = 1'b0;
    de0 = -1; de1 = -1;
    @(negedge clk);
    if0.start = 1'b1; if1.start = 1'b1;
    @(posedge clk); #1;
    if0.start = 1'b0; if1.start = 1'b0;
    gl0 = glitch ? 1'($urandom_range(0, 1)) : 1'b0;
    gl1 = glitch ? 1'($urandom_range(0, 1)) : 1'b0;
    for (int e = 1; e <= 60 && (de0 < 0 || de1 < 0); e++) begin
      @(posedge clk); #1;
      if (e == 1) begin
        chk({nm, ".busy0"}, 32'(if0.busy), 32'd1);
        chk({nm, ".busy1"}, 32'(if1.busy), 32'd1);
      end
      if0.start = rp && (e == 3);
      if1.start = rp && (e == 3);
      if (de0 < 0 && if0.done) de0 = e;
      if (de1 < 0 && if1.done) de1 = e;
      // Only the cycle ending in a SAMPLE edge must carry the true gate value
      gl0 = (glitch && de0 < 0 && ((e + 1) % (S0 + 1)) != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      gl1 = (glitch && de1 < 0 && ((e + 1) % (S1 + 1)) != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    gl0 = 1'b0; gl1 = 1'b0;
    if0.start = 1'b0; if1.start = 1'b0;
    chk({nm, ".done_edge0"}, 32'(de0), 32'(d0));
    chk({nm, ".err0"},       32'(if0.err_cnt), 32'(e0));
    chk({nm, ".fvec0"},      32'(if0.fail_vec), 32'(f0));
    chk({nm, ".pass0"},      32'(if0.pass), 32'(p0));
    chk({nm, ".vec0"},       32'(if0.vec_o), 32'(l0));
    chk({nm, ".idle0"},      32'(if0.busy), 32'd0);
    chk({nm, ".done_edge1"}, 32'(de1), 32'(d1));
    chk({nm, ".err1"},       32'(if1.err_cnt), 32'(e1));
    chk({nm, ".fvec1"},      32'(if1.fail_vec), 32'(f1));
    chk({nm, ".pass1"},      32'(if1.pass), 32'(p1));
    chk({nm, ".vec1"},       32'(if1.vec_o), 32'(l1));
  endtask

  task automatic chk_cleared(input string nm);
    chk({nm, ".vec0"},  32'(if0.vec_o), 32'd0);
    chk({nm, ".busy0"}, 32'(if0.busy), 32'd0);
    chk({nm, ".done0"}, 32'(if0.done), 32'd0);
    chk({nm, ".pass0"}, 32'(if0.pass), 32'd0);
    chk({nm, ".err0"},  32'(if0.err_cnt), 32'd0);
    chk({nm, ".fvec0"}, 32'(if0.fail_vec), 32'd0);
    chk({nm, ".busy1"}, 32'(if1.busy), 32'd0);
    chk({nm, ".err1"},  32'(if1.err_cnt), 32'd0);
    chk({nm, ".done1"}, 32'(if1.done), 32'd0);
  endtask

  initial begin
    if0.start = 1'b0; if1.start = 1'b0;
    gate0 = TT_NAND2; gate1 = TT_XOR2; gl0 = 1'b0; gl1 = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_cleared("reset");
    @(negedge clk) rst_n = 1'b1;

    run_sweep("nand_ok",  TT_NAND2, TT_XOR2, 1'b0, 1'b0);
    run_sweep("and_bad",  4'b1000,  4'b1001, 1'b0, 1'b0);
    run_sweep("glitchy",  TT_NAND2, TT_XOR2, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++)
      run_sweep($sformatf("rnd%0d", i), 4'($urandom), 4'($urandom), 1'b1,
                1'($urandom_range(0, 1)));

    // Abort a failing sweep at edge 5, then confirm a clean rerun
    gate0 = 4'b1000; gate1 = 4'b1001;
    @(negedge clk);
    if0.start = 1'b1; if1.start = 1'b1;
    @(posedge clk); #1;
    if0.start = 1'b0; if1.start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_cleared("midrst");
    @(negedge clk) rst_n = 1'b1;
    run_sweep("post_rst", TT_NAND2, TT_XOR2, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
